alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-issue and writeback stage that sits directly upstream and downstream of the 8-bit ALU in the RISC CPU.
- Accepts decoded 16-bit instructions over a valid/ready handshake and reads an 8x8 register file.
- Drives registered InA/InB/Sel into the combinational ALU, then captures Oper/Zero one cycle later.
- Writes the result back to the register file, updates the zero flag and reports a retire event.

Parameters:
- DATA_W, 8, datapath width; must match the ALU (8).
- R0_ZERO, 1, when 1 register R0 always reads 0 and writes to it are discarded.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  synchronous active-low reset.
- InValid  in  1  instruction present on InInstr.
- InReady  out  1  stage can accept; transfer occurs when InValid && InReady at a rising edge.
- InInstr  in  16  Op[15:13], Rd[12:10], Ra[9:7], ImmEn[6], Rb[5:3] (ImmEn=0) or Imm6[5:0] zero-extended (ImmEn=1).
- AluInA  out  DATA_W  registered operand A to ALU.
- AluInB  out  DATA_W  registered operand B to ALU.
- AluSel  out  3  registered ALU select (= Op).
- AluOper  in  DATA_W  ALU result (combinational from AluInA/B/Sel).
- AluZero  in  1  ALU zero output.
- ZeroFlag  out  1  registered zero flag of last retired instruction.
- RetireValid  out  1  one-cycle pulse per retired instruction.
- RetireRd  out  3  destination of retired instruction.
- RetireData  out  DATA_W  value written.
- DbgAddr  in  3  debug read address.
- DbgData  out  DATA_W  combinational read of regfile[DbgAddr] (0 for R0 when R0_ZERO).

Behaviour:
- Reset (Rst_n=0 at a rising edge): all 8 registers, AluInA, AluInB, AluSel, ZeroFlag, RetireValid, RetireRd, RetireData and the internal ex_valid/ex_rd are cleared to 0. InReady=0 combinationally while Rst_n=0. An in-flight instruction is dropped with no writeback and no retire pulse.
- Pipeline, two stages, no backpressure from retire:
  - ISSUE (accept edge N): AluInA <= rf[Ra]; AluInB <= ImmEn ? {0,Imm6} : rf[Rb]; AluSel <= Op; ex_rd <= Rd; ex_valid <= 1. With no accept, ex_valid <= 0 and the ALU input registers hold their value.
  - EXEC/WB (edge N+1, ex_valid=1): rf[ex_rd] <= AluOper (skipped if ex_rd=0 and R0_ZERO=1); ZeroFlag <= AluZero; RetireValid <= 1; RetireRd <= ex_rd; RetireData <= AluOper. Otherwise RetireValid <= 0; ZeroFlag and RetireRd/RetireData hold.
  - Latency: accept at edge N gives RetireValid high in cycle after edge N+1. Throughput: 1 instruction/cycle absent hazards.
- ZeroFlag reflects AluZero even when the write to R0 is discarded.
- Register file read is combinational from the current array contents. A write at edge N+1 is visible to reads from edge N+1 on.
- RAW hazard: ex_valid=1, ex_rd!=0 (or R0_ZERO=0), and Ra==ex_rd, or Rb==ex_rd with ImmEn=0. Handling depends on FWD_EN (below).
- InReady = Rst_n && !(hazard stall condition). Never depends on RetireValid.
- All arithmetic is modulo 2^DATA_W; the ALU handles the operation and this stage only moves operands.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: on a RAW hazard the matching operand takes AluOper instead of the rf read. No stall; InReady = Rst_n.
- Undefined: on a RAW hazard InReady is driven low for exactly one cycle. The instruction is accepted the next cycle, reads the written-back value and incurs a 1-cycle bubble (RetireValid low for one cycle).

Test Plan:
- Reset mid-operation: accept ADD, assert Rst_n=0 on next edge -> no RetireValid, all regs/DbgData 0, InReady=0 during reset.
- Immediate load: ADD R1,R0,#5 then ADD R2,R0,#3 back-to-back -> RetireData 5 then 3 on consecutive cycles, DbgData(R1)=5, (R2)=3, ZeroFlag=0.
- Zero flag: with R1=5, SUB R3,R1,#5 -> RetireData 0, ZeroFlag=1. Then OR R4,R1,R0 -> RetireData 5, ZeroFlag=0.
- Dependency chain: ADD R1,R0,#7 immediately followed by ADD R2,R1,R1 -> R2=14. With ALU_ISSUE_FWD_EN, no InReady drop. Without it, InReady low one cycle and a 1-cycle RetireValid gap.
- R0 write: XOR R0,R0,#9 (R0_ZERO=1) -> RetireValid=1, RetireData=9, ZeroFlag=0, DbgData(R0) stays 0. Next ADD R5,R0,#0 -> 0 with no stall.
- Idle gaps: InValid toggled 1,0,1 -> RetireValid 1,0,1 pattern two edges later. AluInA/B/Sel hold during the gap.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_stage_if : instruction, ALU, retire and debug signal bundle |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_issue_stage_if #(
    parameter int DATA_W = 8
);
    logic              InValid;
    logic              InReady;
    logic [15:0]       InInstr;
    logic [DATA_W-1:0] AluInA;
    logic [DATA_W-1:0] AluInB;
    logic [2:0]        AluSel;
    logic [DATA_W-1:0] AluOper;
    logic              AluZero;
    logic              ZeroFlag;
    logic              RetireValid;
    logic [2:0]        RetireRd;
    logic [DATA_W-1:0] RetireData;
    logic [2:0]        DbgAddr;
    logic [DATA_W-1:0] DbgData;

    // master: instruction source plus ALU; slave: the issue stage itself
    modport master (
        output InValid, InInstr, AluOper, AluZero, DbgAddr,
        input  InReady, AluInA, AluInB, AluSel, ZeroFlag,
               RetireValid, RetireRd, RetireData, DbgData
    );

    modport slave (
        input  InValid, InInstr, AluOper, AluZero, DbgAddr,
        output InReady, AluInA, AluInB, AluSel, ZeroFlag,
               RetireValid, RetireRd, RetireData, DbgData
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_stage : operand issue + writeback around the 8-bit ALU     |
// | Optional macro ALU_ISSUE_FWD_EN: forward AluOper instead of stalling |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_issue_stage #(
    parameter int DATA_W  = 8,
    parameter int R0_ZERO = 1
) (
    input  wire logic         Clk,
    input  wire logic         Rst_n,
    alu_issue_stage_if.slave  bus
);
    localparam bit c_r0_hard = (R0_ZERO != 0);

    logic [DATA_W-1:0] r_rf [0:7];
    logic              r_ex_valid;
    logic [2:0]        r_ex_rd;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_sel;
    logic              r_zero;
    logic              r_ret_valid;
    logic [2:0]        r_ret_rd;
    logic [DATA_W-1:0] r_ret_data;

    logic [2:0]        w_op, w_rd, w_ra, w_rb;
    logic              w_imm_en;
    logic [5:0]        w_imm6;
    logic [DATA_W-1:0] w_rf_a, w_rf_b, w_opnd_a, w_opnd_b_reg, w_opnd_b;
    logic              w_ex_writes, w_haz_a, w_haz_b, w_stall, w_ready, w_accept;

    assign w_op     = bus.InInstr[15:13];
    assign w_rd     = bus.InInstr[12:10];
    assign w_ra     = bus.InInstr[9:7];
    assign w_imm_en = bus.InInstr[6];
    assign w_rb     = bus.InInstr[5:3];
    assign w_imm6   = bus.InInstr[5:0];

    assign w_rf_a = (c_r0_hard && w_ra == 3'd0) ? '0 : r_rf[w_ra];
    assign w_rf_b = (c_r0_hard && w_rb == 3'd0) ? '0 : r_rf[w_rb];

    // Only an in-flight result that will really land in the regfile can conflict
    assign w_ex_writes = r_ex_valid && ((r_ex_rd != 3'd0) || !c_r0_hard);
    assign w_haz_a     = w_ex_writes && (w_ra == r_ex_rd);
    assign w_haz_b     = w_ex_writes && !w_imm_en && (w_rb == r_ex_rd);

`ifdef ALU_ISSUE_FWD_EN
    assign w_opnd_a     = w_haz_a ? bus.AluOper : w_rf_a;
    assign w_opnd_b_reg = w_haz_b ? bus.AluOper : w_rf_b;
    assign w_stall      = 1'b0;
`else
    // Holding off one cycle lets the writeback land before the operand read
    assign w_opnd_a     = w_rf_a;
    assign w_opnd_b_reg = w_rf_b;
    assign w_stall      = w_haz_a || w_haz_b;
`endif

    assign w_opnd_b = w_imm_en ? {{(DATA_W-6){1'b0}}, w_imm6} : w_opnd_b_reg;
    assign w_ready  = Rst_n && !w_stall;
    assign w_accept = bus.InValid && w_ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_rf        <= '{default: '0};
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= 3'd0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 3'd0;
            r_zero      <= 1'b0;
            r_ret_valid <= 1'b0;
            r_ret_rd    <= 3'd0;
            r_ret_data  <= '0;
        end else begin
            r_ex_valid  <= w_accept;
            r_ret_valid <= r_ex_valid;
            if (w_accept) begin
                r_alu_a   <= w_opnd_a;
                r_alu_b   <= w_opnd_b;
                r_alu_sel <= w_op;
                r_ex_rd   <= w_rd;
            end
            if (r_ex_valid) begin
                if (w_ex_writes) begin
                    r_rf[r_ex_rd] <= bus.AluOper;
                end
                r_zero     <= bus.AluZero;
                r_ret_rd   <= r_ex_rd;
                r_ret_data <= bus.AluOper;
            end
        end
    end

    assign bus.InReady     = w_ready;
    assign bus.AluInA      = r_alu_a;
    assign bus.AluInB      = r_alu_b;
    assign bus.AluSel      = r_alu_sel;
    assign bus.ZeroFlag    = r_zero;
    assign bus.RetireValid = r_ret_valid;
    assign bus.RetireRd    = r_ret_rd;
    assign bus.RetireData  = r_ret_data;
    assign bus.DbgData     = (c_r0_hard && bus.DbgAddr == 3'd0) ? '0 : r_rf[bus.DbgAddr];
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_issue_stage : directed self-checking bench with a small ALU   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_issue_stage;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_errors;

    alu_issue_stage_if #(.DATA_W(8)) bus ();

    alu_issue_stage #(.DATA_W(8), .R0_ZERO(1)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference ALU sitting on the DUT's registered operands
    always_comb begin
        case (bus.AluSel)
            OP_ADD:  bus.AluOper = bus.AluInA + bus.AluInB;
            OP_SUB:  bus.AluOper = bus.AluInA - bus.AluInB;
            OP_AND:  bus.AluOper = bus.AluInA & bus.AluInB;
            OP_OR:   bus.AluOper = bus.AluInA | bus.AluInB;
            OP_XOR:  bus.AluOper = bus.AluInA ^ bus.AluInB;
            default: bus.AluOper = 8'h00;
        endcase
        bus.AluZero = (bus.AluOper == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] imm_instr(input logic [2:0] op, input logic [2:0] rd,
                                              input logic [2:0] ra, input logic [5:0] imm);
        return {op, rd, ra, 1'b1, imm};
    endfunction

    function automatic logic [15:0] reg_instr(input logic [2:0] op, input logic [2:0] rd,
                                              input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, 1'b0, rb, 3'b000};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic present(input logic [15:0] instr);
        bus.InValid = 1'b1;
        bus.InInstr = instr;
        #1;
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
        #1;
    endtask

    task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        bus.DbgAddr = addr;
        #1;
        check(tag, {24'd0, bus.DbgData}, {24'd0, exp});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        Rst_n       = 1'b0;
        bus.InValid = 1'b0;
        bus.InInstr = 16'h0000;
        bus.DbgAddr = 3'd0;

        // Reset state
        tick();
        tick();
        present(imm_instr(OP_ADD, 3'd1, 3'd0, 6'd5));
        check("ready_in_reset", {31'd0, bus.InReady}, 32'd0);
        idle();
        Rst_n = 1'b1;
        tick();
        check("rst_alu_a", {24'd0, bus.AluInA}, 32'd0);
        check("rst_alu_sel", {29'd0, bus.AluSel}, 32'd0);
        check("rst_zero", {31'd0, bus.ZeroFlag}, 32'd0);
        check("rst_retire", {31'd0, bus.RetireValid}, 32'd0);

        // Reset mid-operation drops the accepted instruction
        present(imm_instr(OP_ADD, 3'd1, 3'd0, 6'd5));
        check("ready_idle", {31'd0, bus.InReady}, 32'd1);
        tick();
        idle();
        Rst_n = 1'b0;
        #1;
        check("ready_low_rst", {31'd0, bus.InReady}, 32'd0);
        tick();
        check("midrst_retire", {31'd0, bus.RetireValid}, 32'd0);
        check("midrst_alu_b", {24'd0, bus.AluInB}, 32'd0);
        dbg_check("midrst_r1", 3'd1, 8'd0);
        tick();
        check("midrst_retire2", {31'd0, bus.RetireValid}, 32'd0);
        Rst_n = 1'b1;
        tick();

        // Back-to-back immediate loads
        present(imm_instr(OP_ADD, 3'd1, 3'd0, 6'd5));
        tick();
        present(imm_instr(OP_ADD, 3'd2, 3'd0, 6'd3));
        check("imm_ready", {31'd0, bus.InReady}, 32'd1);
        tick();
        check("imm1_valid", {31'd0, bus.RetireValid}, 32'd1);
        check("imm1_rd", {29'd0, bus.RetireRd}, 32'd1);
        check("imm1_data", {24'd0, bus.RetireData}, 32'd5);
        idle();
        tick();
        check("imm2_valid", {31'd0, bus.RetireValid}, 32'd1);
        check("imm2_rd", {29'd0, bus.RetireRd}, 32'd2);
        check("imm2_data", {24'd0, bus.RetireData}, 32'd3);
        check("imm2_zero", {31'd0, bus.ZeroFlag}, 32'd0);
        dbg_check("dbg_r1", 3'd1, 8'd5);
        dbg_check("dbg_r2", 3'd2, 8'd3);

        // Zero flag set then cleared
        present(imm_instr(OP_SUB, 3'd3, 3'd1, 6'd5));
        tick();
        idle();
        tick();
        check("sub_data", {24'd0, bus.RetireData}, 32'd0);
        check("sub_zero", {31'd0, bus.ZeroFlag}, 32'd1);
        present(reg_instr(OP_OR, 3'd4, 3'd1, 3'd0));
        tick();
        idle();
        tick();
        check("or_data", {24'd0, bus.RetireData}, 32'd5);
        check("or_zero", {31'd0, bus.ZeroFlag}, 32'd0);
        dbg_check("dbg_r4", 3'd4, 8'd5);

        // Dependency chain R1 -> R2
        present(imm_instr(OP_ADD, 3'd1, 3'd0, 6'd7));
        tick();
        present(reg_instr(OP_ADD, 3'd2, 3'd1, 3'd1));
`ifdef ALU_ISSUE_FWD_EN
        check("dep_ready", {31'd0, bus.InReady}, 32'd1);
        tick();
        check("dep1_data", {24'd0, bus.RetireData}, 32'd7);
        idle();
        tick();
`else
        check("dep_ready_stall", {31'd0, bus.InReady}, 32'd0);
        tick();
        check("dep1_data", {24'd0, bus.RetireData}, 32'd7);
        check("dep_ready_after", {31'd0, bus.InReady}, 32'd1);
        tick();
        check("dep_bubble", {31'd0, bus.RetireValid}, 32'd0);
        idle();
        tick();
`endif
        check("dep2_valid", {31'd0, bus.RetireValid}, 32'd1);
        check("dep2_rd", {29'd0, bus.RetireRd}, 32'd2);
        check("dep2_data", {24'd0, bus.RetireData}, 32'd14);
        dbg_check("dbg_r2_dep", 3'd2, 8'd14);

        // Writes to R0 are discarded but still retire and set ZeroFlag
        present(imm_instr(OP_XOR, 3'd0, 3'd0, 6'd9));
        tick();
        present(imm_instr(OP_ADD, 3'd5, 3'd0, 6'd0));
        check("r0_no_stall", {31'd0, bus.InReady}, 32'd1);
        tick();
        check("r0_valid", {31'd0, bus.RetireValid}, 32'd1);
        check("r0_data", {24'd0, bus.RetireData}, 32'd9);
        check("r0_zero", {31'd0, bus.ZeroFlag}, 32'd0);
        dbg_check("dbg_r0", 3'd0, 8'd0);
        idle();
        tick();
        check("r5_data", {24'd0, bus.RetireData}, 32'd0);
        check("r5_rd", {29'd0, bus.RetireRd}, 32'd5);
        check("r5_zero", {31'd0, bus.ZeroFlag}, 32'd1);

        // Idle gaps: 1,0,1 in -> 1,0,1 retire, operands hold through the gap
        tick();
        present(imm_instr(OP_ADD, 3'd6, 3'd0, 6'd1));
        tick();
        check("gap_e1_ret", {31'd0, bus.RetireValid}, 32'd0);
        idle();
        tick();
        check("gap_e2_ret", {31'd0, bus.RetireValid}, 32'd1);
        check("gap_hold_b", {24'd0, bus.AluInB}, 32'd1);
        check("gap_hold_sel", {29'd0, bus.AluSel}, {29'd0, OP_ADD});
        present(imm_instr(OP_AND, 3'd7, 3'd0, 6'd2));
        tick();
        check("gap_e3_ret", {31'd0, bus.RetireValid}, 32'd0);
        check("gap_new_b", {24'd0, bus.AluInB}, 32'd2);
        idle();
        tick();
        check("gap_e4_ret", {31'd0, bus.RetireValid}, 32'd1);
        check("gap_e4_rd", {29'd0, bus.RetireRd}, 32'd7);
        tick();
        check("gap_e5_ret", {31'd0, bus.RetireValid}, 32'd0);
        dbg_check("dbg_r6", 3'd6, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
